m_dm_pipe: RTL

- Parametrised data memory for the pipelined MIPS core; next generation of the M-stage DM.
- Adds a valid/ready request port, configurable access latency (LATENCY cycles) and signed/unsigned sub-word loads (lb/lbu/lh/lhu).
- Adds misalignment/out-of-range exception reporting and a post-reset sequential clear of the array.
- Sits between the M-stage pipeline register and the W-stage; the hazard unit stalls on !req_ready or pending response.

---
 rtl/m_dm_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/m_dm_pipe.sv
// Pipelined data memory with a valid/ready request port, LATENCY-cycle access, sub-word loads/stores,
// fault reporting and a post-reset sequential clear. Define DM_TRACE_EN to print every committed store.
module m_dm_pipe #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        init_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_HU = 3'd2;
    localparam logic [2:0] OP_B  = 3'd3;
    localparam logic [2:0] OP_BU = 3'd4;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [AW-1:0] init_ptr;
    logic [2:0]    cnt;
    logic          we_reg;
    logic [2:0]    op_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   pc_reg;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word_reg;

    logic          commit;
    logic          exc;
    logic [3:0]    byte_en;
    logic [31:0]   lane_wdata;
    logic [31:0]   merged;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_data;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    assign commit = (state == WAIT) && (cnt == 3'd0);

    assign exc = (op_reg > OP_BU)
               || ((op_reg == OP_W) && (addr_reg[1:0] != 2'b00))
               || (((op_reg == OP_H) || (op_reg == OP_HU)) && addr_reg[0])
               || ({2'b00, addr_reg[31:2]} >= 32'(DEPTH));

    always_comb begin
        case (op_reg)
            OP_W:        lane_wdata = wdata_reg;
            OP_H, OP_HU: lane_wdata = {2{wdata_reg[15:0]}};
            default:     lane_wdata = {4{wdata_reg[7:0]}};
        endcase
    end

    // Read-modify-write merge: untouched lanes keep the word fetched at acceptance
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign byte_en[gi] = (op_reg == OP_W)
                          || (((op_reg == OP_H) || (op_reg == OP_HU)) && (addr_reg[1] == LANE[1]))
                          || (((op_reg == OP_B) || (op_reg == OP_BU)) && (addr_reg[1:0] == LANE));
        assign merged[8*gi +: 8] = byte_en[gi] ? lane_wdata[8*gi +: 8] : rd_word_reg[8*gi +: 8];
    end

    assign half_sel = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        case (addr_reg[1:0])
            2'd0:    byte_sel = rd_word_reg[7:0];
            2'd1:    byte_sel = rd_word_reg[15:8];
            2'd2:    byte_sel = rd_word_reg[23:16];
            default: byte_sel = rd_word_reg[31:24];
        endcase
    end

    always_comb begin
        case (op_reg)
            OP_W:    load_data = rd_word_reg;
            OP_H:    load_data = {{16{half_sel[15]}}, half_sel};
            OP_HU:   load_data = {16'h0000, half_sel};
            OP_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   load_data = {24'h000000, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

    // Single write port shared by the clear sweep and store commits; gated so reset blocks any write
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = 32'h0;
        if (!reset) begin
            if (state == INIT) begin
                mem_we   = 1'b1;
                mem_widx = init_ptr;
            end else if (commit && we_reg && !exc) begin
                mem_we    = 1'b1;
                mem_widx  = addr_reg[AW+1:2];
                mem_wdata = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Word is fetched on the accepting edge; nothing else can write it before commit
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            rd_word_reg <= mem[req_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            init_ptr   <= '0;
            cnt        <= 3'd0;
            we_reg     <= 1'b0;
            op_reg     <= 3'd0;
            addr_reg   <= 32'h0;
            wdata_reg  <= 32'h0;
            pc_reg     <= 32'h0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_exc   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == AW'(DEPTH - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        op_reg    <= req_op;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        pc_reg    <= pc;
                        cnt       <= 3'(LATENCY - 1);
                        state     <= WAIT;
                        req_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_exc   <= exc;
                        resp_rdata <= (exc || we_reg) ? 32'h0 : load_data;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_exc   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (mem_we && (state == WAIT)) begin
            $display("%d@%h: *%h <= %h", $time, pc_reg, {addr_reg[31:2], 2'b00}, merged);
        end
    end
`else
    logic [31:0] unused_pc;
    assign unused_pc = pc_reg;
`endif

endmodule
